// File: rtl/ctrl_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : ctrl_defs
//  Purpose  : Shared types and constants for the vector control unit.
//  Revision : 1.0  initial release
// ============================================================================
package ctrl_defs;

    localparam logic [1:0] TYPE_SYS  = 2'b00;
    localparam logic [1:0] TYPE_DP   = 2'b01;
    localparam logic [1:0] TYPE_MEM  = 2'b10;
    localparam logic [1:0] TYPE_CTRL = 2'b11;

    localparam logic [2:0] OP_CMP  = 3'b100;
    localparam logic [2:0] ALU_ADD = 3'b000;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       flags_write;
        logic       reg_src;
        logic [1:0] vsi_flag;
        logic [2:0] alu_control;
        logic       is_vec;
        logic       is_mem;
    } ctrl_word_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_decoder
//  Purpose  : Combinational decode of the 7-bit instruction field.
//  Revision : 1.0  initial release
// ============================================================================
module ctrl_decoder
    import ctrl_defs::*;
(
    input  logic [6:0] Id,
    output ctrl_word_t word_o
);

    logic [1:0] typ;
    logic [2:0] op;

    assign typ = Id[6:5];
    assign op  = Id[4:2];

    always_comb begin
        word_o             = '0;
        word_o.vsi_flag    = Id[1:0];
        word_o.alu_control = op;
        case (typ)
            TYPE_SYS: begin
                word_o.vsi_flag = 2'b00;
            end
            TYPE_DP: begin
                word_o.reg_write   = (op != OP_CMP);
                word_o.flags_write = (op == OP_CMP);
                word_o.is_vec      = Id[1];
            end
            TYPE_MEM: begin
                // Id[4] selects store (1) or load (0); address always computed by add.
                word_o.alu_control = ALU_ADD;
                word_o.is_mem      = 1'b1;
                word_o.is_vec      = Id[1];
                word_o.reg_src     = Id[4];
                word_o.mem_write   = Id[4];
                word_o.mem_to_reg  = ~Id[4];
                word_o.reg_write   = ~Id[4];
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/vector_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : vector_control_unit
//  Purpose  : Issues registered control words, splitting vector ops into beats.
//  Revision : 1.0  initial release
// ============================================================================
module vector_control_unit
    import ctrl_defs::*;
#(
    parameter int VLEN_LANES = 4,
    parameter int DP_LANES   = 4,
    parameter int GIDX_W     = ((VLEN_LANES / DP_LANES) > 1) ? $clog2(VLEN_LANES / DP_LANES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [6:0]        Id,
    output logic              id_ready,
    input  logic              stall_in,
    input  logic              mem_ready,
    input  logic              flush,
    output logic              ctrl_valid,
    output logic              RegWrite,
    output logic              MemtoReg,
    output logic              MemWrite,
    output logic              FlagsWrite,
    output logic              RegSrc,
    output logic [1:0]        VSIFlag,
    output logic [2:0]        ALUControl,
    output logic [GIDX_W-1:0] group_idx,
    output logic              last_group
);

    localparam int GROUPS = VLEN_LANES / DP_LANES;

    if ((VLEN_LANES % DP_LANES) != 0) begin : g_bad_lanes
        $error("DP_LANES must divide VLEN_LANES");
    end

    state_t            state_q;
    ctrl_word_t        word_q;
    ctrl_word_t        dec_word;
    logic [GIDX_W-1:0] gidx_q;
    logic              busy;
    logic              beat_done;
    logic              accept;

    ctrl_decoder u_dec (
        .Id     (Id),
        .word_o (dec_word)
    );

    assign busy       = (state_q == ST_BUSY);
    assign last_group = busy & (~word_q.is_vec | (gidx_q == GIDX_W'(GROUPS - 1)));
    assign beat_done  = busy & ~stall_in & (~word_q.is_mem | mem_ready);
    assign id_ready   = ~flush & ~rst & (~busy | (beat_done & last_group));
    assign accept     = id_valid & id_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            gidx_q  <= '0;
        end else if (accept) begin
            state_q <= ST_BUSY;
            word_q  <= dec_word;
            gidx_q  <= '0;
        end else if (beat_done) begin
            if (last_group) begin
                state_q <= ST_IDLE;
                word_q  <= '0;
                gidx_q  <= '0;
            end else begin
                gidx_q <= gidx_q + GIDX_W'(1);
            end
        end
    end

    // Flags are written once per instruction, on the final element group.
    assign ctrl_valid = busy;
    assign RegWrite   = busy & word_q.reg_write;
    assign MemtoReg   = busy & word_q.mem_to_reg;
    assign MemWrite   = busy & word_q.mem_write;
    assign FlagsWrite = last_group & word_q.flags_write;
    assign RegSrc     = word_q.reg_src;
    assign VSIFlag    = word_q.vsi_flag;
    assign ALUControl = word_q.alu_control;
    assign group_idx  = gidx_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vector_control_unit
//  Purpose  : Directed and randomized checks of vector_control_unit (GROUPS=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_vector_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [6:0] Id = 7'd0;
    logic       id_ready;
    logic       stall_in = 1'b0;
    logic       mem_ready = 1'b1;
    logic       flush = 1'b0;
    logic       ctrl_valid, RegWrite, MemtoReg, MemWrite, FlagsWrite, RegSrc;
    logic [1:0] VSIFlag;
    logic [2:0] ALUControl;
    logic [1:0] group_idx;
    logic       last_group;

    int n_tests = 0;
    int n_fail  = 0;

    logic [13:0] obs;
    logic [5:0]  obs_idle;
    assign obs = {ctrl_valid, RegWrite, MemtoReg, MemWrite, FlagsWrite, RegSrc,
                  VSIFlag, ALUControl, group_idx, last_group};
    assign obs_idle = {ctrl_valid, RegWrite, MemtoReg, MemWrite, FlagsWrite, last_group};

    localparam logic [6:0] I_ADD = 7'b0100000;
    localparam logic [6:0] I_CMP = 7'b0110010;
    localparam logic [6:0] I_STR = 7'b1010010;
    localparam logic [6:0] I_LDR = 7'b1000000;

    vector_control_unit #(.VLEN_LANES(4), .DP_LANES(1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .Id(Id), .id_ready(id_ready),
        .stall_in(stall_in), .mem_ready(mem_ready), .flush(flush),
        .ctrl_valid(ctrl_valid), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .MemWrite(MemWrite), .FlagsWrite(FlagsWrite), .RegSrc(RegSrc),
        .VSIFlag(VSIFlag), .ALUControl(ALUControl), .group_idx(group_idx),
        .last_group(last_group)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] ew(input logic cv, rw, mtr, mw, fw, rs,
                                       input logic [1:0] vsi, input logic [2:0] alu,
                                       input logic [1:0] gi, input logic lg);
        return {cv, rw, mtr, mw, fw, rs, vsi, alu, gi, lg};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_tests++;
        if (obs !== 14'd0) begin
            n_fail++; $display("FAIL reset_outputs got %b want %b", obs, 14'd0);
        end
        n_tests++;
        if (id_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_id_ready got %b want 0", id_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if (id_ready !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_id_ready got %b want 1", id_ready);
        end
    endtask

    task automatic test_scalar_add();
        @(negedge clk);
        id_valid = 1'b1; Id = I_ADD;
        @(negedge clk);
        id_valid = 1'b0;
        #1;
        n_tests++;
        if (obs !== ew(1,1,0,0,0,0,2'b00,3'b000,2'd0,1)) begin
            n_fail++; $display("FAIL add_word got %b want %b", obs, ew(1,1,0,0,0,0,2'b00,3'b000,2'd0,1));
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (obs_idle !== 6'd0) begin
            n_fail++; $display("FAIL add_idle got %b want 000000", obs_idle);
        end
    endtask

    task automatic test_vector_cmp();
        @(negedge clk);
        id_valid = 1'b1; Id = I_CMP;
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            id_valid = 1'b0;
            #1;
            n_tests++;
            if (obs !== ew(1,0,0,0,g==3,0,2'b10,3'b100,2'(g),g==3)) begin
                n_fail++; $display("FAIL cmp_group%0d got %b want %b", g, obs,
                                   ew(1,0,0,0,g==3,0,2'b10,3'b100,2'(g),g==3));
            end
            n_tests++;
            if (id_ready !== (g == 3)) begin
                n_fail++; $display("FAIL cmp_id_ready%0d got %b want %b", g, id_ready, g == 3);
            end
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (obs_idle !== 6'd0) begin
            n_fail++; $display("FAIL cmp_idle got %b want 000000", obs_idle);
        end
    endtask

    task automatic test_vector_str_wait();
        logic [1:0] gs [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};
        logic       mr [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        @(negedge clk);
        id_valid = 1'b1; Id = I_STR; mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            id_valid = 1'b0; mem_ready = mr[i];
            #1;
            n_tests++;
            if (obs !== ew(1,0,0,1,0,1,2'b10,3'b000,gs[i],gs[i]==2'd3)) begin
                n_fail++; $display("FAIL str_cycle%0d got %b want %b", i, obs,
                                   ew(1,0,0,1,0,1,2'b10,3'b000,gs[i],gs[i]==2'd3));
            end
        end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        n_tests++;
        if (obs_idle !== 6'd0) begin
            n_fail++; $display("FAIL str_idle got %b want 000000", obs_idle);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        id_valid = 1'b1; Id = I_LDR;
        @(negedge clk);
        Id = I_ADD;
        #1;
        n_tests++;
        if (obs !== ew(1,1,1,0,0,0,2'b00,3'b000,2'd0,1)) begin
            n_fail++; $display("FAIL b2b_ldr got %b want %b", obs, ew(1,1,1,0,0,0,2'b00,3'b000,2'd0,1));
        end
        n_tests++;
        if (id_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_id_ready got %b want 1", id_ready);
        end
        @(negedge clk);
        id_valid = 1'b0;
        #1;
        n_tests++;
        if (obs !== ew(1,1,0,0,0,0,2'b00,3'b000,2'd0,1)) begin
            n_fail++; $display("FAIL b2b_add got %b want %b", obs, ew(1,1,0,0,0,0,2'b00,3'b000,2'd0,1));
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (obs_idle !== 6'd0) begin
            n_fail++; $display("FAIL b2b_idle got %b want 000000", obs_idle);
        end
    endtask

    task automatic test_stall_flush();
        logic [1:0] gs [7] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3};
        logic       st [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        @(negedge clk);
        id_valid = 1'b1; Id = I_CMP;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            id_valid = 1'b0; stall_in = st[i];
            #1;
            n_tests++;
            if (obs !== ew(1,0,0,0,gs[i]==2'd3,0,2'b10,3'b100,gs[i],gs[i]==2'd3)) begin
                n_fail++; $display("FAIL stall_cycle%0d got %b want %b", i, obs,
                                   ew(1,0,0,0,gs[i]==2'd3,0,2'b10,3'b100,gs[i],gs[i]==2'd3));
            end
        end
        @(negedge clk);
        stall_in = 1'b0;
        id_valid = 1'b1; Id = I_CMP;
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            id_valid = 1'b0;
        end
        // now at group 2: flush with a competing instruction
        flush = 1'b1; id_valid = 1'b1; Id = I_ADD;
        #1;
        n_tests++;
        if (id_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_id_ready got %b want 0", id_ready);
        end
        @(negedge clk);
        flush = 1'b0; id_valid = 1'b0;
        #1;
        n_tests++;
        if ({ctrl_valid, group_idx, last_group, RegWrite} !== 5'd0) begin
            n_fail++; $display("FAIL flush_next got %b want 00000",
                               {ctrl_valid, group_idx, last_group, RegWrite});
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (obs_idle !== 6'd0) begin
            n_fail++; $display("FAIL flush_not_accepted got %b want 000000", obs_idle);
        end
    endtask

    task automatic test_random();
        bit         m_busy = 1'b0;
        logic [6:0] m_id = '0;
        int         m_g = 0;
        logic [1:0] typ;
        logic [2:0] op;
        bit         vec, mem, last, bd, rdy;
        logic [13:0] exp_w;
        @(negedge clk);
        rst = 1'b1; id_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 400; c++) begin
            id_valid  = ($urandom_range(0, 99) < 60);
            Id        = 7'($urandom);
            stall_in  = ($urandom_range(0, 99) < 25);
            mem_ready = ($urandom_range(0, 99) < 60);
            flush     = ($urandom_range(0, 99) < 5);
            typ  = m_id[6:5];
            op   = m_id[4:2];
            vec  = m_id[1] && (typ == 2'b01 || typ == 2'b10);
            mem  = (typ == 2'b10);
            last = m_busy && (m_g == (vec ? 3 : 0));
            bd   = m_busy && !stall_in && (!mem || mem_ready);
            rdy  = !flush && (!m_busy || (bd && last));
            #1;
            n_tests++;
            if (id_ready !== rdy) begin
                n_fail++; $display("FAIL rnd_id_ready cyc %0d got %b want %b", c, id_ready, rdy);
            end
            n_tests++;
            if (m_busy) begin
                exp_w = ew(1'b1,
                           (typ == 2'b01) ? (op != 3'b100) : (mem && !m_id[4]),
                           mem && !m_id[4],
                           mem && m_id[4],
                           (typ == 2'b01) && (op == 3'b100) && last,
                           mem && m_id[4],
                           (typ == 2'b00) ? 2'b00 : m_id[1:0],
                           mem ? 3'b000 : op,
                           2'(m_g),
                           last);
                if (obs !== exp_w) begin
                    n_fail++; $display("FAIL rnd_word cyc %0d id %b got %b want %b", c, m_id, obs, exp_w);
                end
            end else if (obs_idle !== 6'd0) begin
                n_fail++; $display("FAIL rnd_idle cyc %0d got %b want 000000", c, obs_idle);
            end
            @(posedge clk);
            if (flush) begin
                m_busy = 1'b0; m_g = 0;
            end else if (id_valid && rdy) begin
                m_busy = 1'b1; m_id = Id; m_g = 0;
            end else if (bd) begin
                if (last) m_busy = 1'b0;
                else      m_g++;
            end
            @(negedge clk);
        end
        id_valid = 1'b0; flush = 1'b0; stall_in = 1'b0; mem_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_scalar_add();
        test_vector_cmp();
        test_vector_str_wait();
        test_back_to_back();
        test_stall_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
